// File: rtl/melodia_secuenciador.sv
// Melody sequencer: walks a {note, duration} table in a synchronous ROM and drives the
// tone-mux select for dur*TICK_DIV clocks per entry, followed by an optional silent gap.
module melodia_secuenciador #(
  parameter int unsigned TICK_DIV  = 2500000,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NOTE_W    = 4,
  parameter int unsigned DUR_W     = 4,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note_sel,
  output logic                    note_en,
  output logic                    beat_tick,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam int unsigned GapW = $clog2(GAP_TICKS + 2);
  localparam logic [PreW-1:0] PreMax  = PreW'(TICK_DIV - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 2);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StPlay,
    StGap,
    StDone
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [PreW-1:0]   presc;
  logic [DUR_W-1:0]  dur_cnt;
  logic [GapW-1:0]   gap_cnt;

  logic [DUR_W-1:0]  rom_dur;
  logic [NOTE_W-1:0] rom_note;
  logic              tick;

  assign rom_dur  = rom_data[DUR_W-1:0];
  assign rom_note = rom_data[NOTE_W+DUR_W-1 -: NOTE_W];
  assign tick     = (presc == PreMax);
  // The pointer register is the ROM address, so FETCH presents it with no extra stage.
  assign rom_addr = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      ptr       <= '0;
      presc     <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      note_sel  <= '0;
      note_en   <= 1'b0;
      beat_tick <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (stop) begin
      state     <= StIdle;
      ptr       <= '0;
      presc     <= '0;
      note_en   <= 1'b0;
      beat_tick <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      beat_tick <= 1'b0;
      // Beat prescaler runs only while a note or gap is being timed.
      if (state == StPlay || state == StGap) begin
        presc     <= tick ? '0 : presc + PreW'(1);
        beat_tick <= !tick && (presc == PreLast);
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            state <= StFetch;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        StFetch: begin
          state <= StWait;
        end
        StWait: begin
          if (rom_dur != '0) begin
            note_sel <= rom_note;
            dur_cnt  <= rom_dur;
            presc    <= '0;
            note_en  <= 1'b1;
            state    <= StPlay;
          end else if (loop_en && ptr != '0) begin
            ptr   <= '0;
            state <= StFetch;
          end else begin
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StPlay: begin
          if (tick) begin
            if (dur_cnt > DUR_W'(1)) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end else begin
              note_en <= 1'b0;
              if (GAP_TICKS != 0) begin
                gap_cnt <= GapW'(GAP_TICKS);
                state   <= StGap;
              end else begin
                ptr   <= ptr + ADDR_W'(1);
                state <= StFetch;
              end
            end
          end
        end
        StGap: begin
          if (tick) begin
            if (gap_cnt > GapW'(1)) begin
              gap_cnt <= gap_cnt - GapW'(1);
            end else begin
              ptr   <= ptr + ADDR_W'(1);
              state <= StFetch;
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
